dff_rr_arbiter: RTL

DFF_RR_ARBITER -- requirements
Module: dff_rr_arbiter

---
 rtl/dff_rr_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/dff_rr_arbiter.sv
// Round-robin arbiter in front of a shared W-bit register. A winner may lock
// ownership and keep writing each cycle until it drops req or lock.
//
// state | meaning
// IDLE  | arbitrating round-robin from ptr among active requesters
// OWN   | locked to owner; only the owner may write, others are ignored
module dff_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         lock,
  input  logic [N*W-1:0]       din,
  output logic [N-1:0]         gnt,
  output logic [W-1:0]         dout,
  output logic                 valid,
  output logic [$clog2(N)-1:0] owner
);

  localparam int OW = $clog2(N);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [W-1:0]  dout_q, dout_d;
  logic [N-1:0]  gnt_q, gnt_d;

  logic [OW-1:0] sel;
  logic [OW-1:0] idx;
  logic          found;

  // First active requester at or after ptr, wrapping modulo N.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = OW'((int'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    dout_d  = dout_q;
    gnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          dout_d     = din[int'(sel)*W +: W];
          gnt_d[sel] = 1'b1;
          owner_d    = sel;
          ptr_d      = (sel == OW'(N-1)) ? '0 : sel + 1'b1;
          state_d    = lock[sel] ? ST_OWN : ST_IDLE;
        end
      end
      default: begin
        if (req[owner_q] && lock[owner_q]) begin
          dout_d         = din[int'(owner_q)*W +: W];
          gnt_d[owner_q] = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      dout_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      dout_q  <= dout_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign dout  = dout_q;
  assign owner = owner_q;
  assign valid = |gnt_q;

endmodule
